seq_restoring_div: RTL and testbench

//   Multi-cycle unsigned restoring divider: the inverse operation to the ripple adders in this

---
 rtl/div_pkg.sv | 27 ++
 rtl/seq_restoring_div_rbs_sub.sv | 33 +++
 rtl/seq_restoring_div.sv | 120 ++++++++++++
 tb/tb_seq_restoring_div.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
//==============================================================================
// Module  : div_pkg
// Brief   : Shared state encoding and sizing helpers for the restoring divider.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef logic [1:0] div_state_t;

    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t CALC = 2'd1;
    localparam div_state_t DONE = 2'd2;

    // Bits needed to count WIDTH iterations (0..WIDTH-1).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

`default_nettype wire

// File: rtl/seq_restoring_div_rbs_sub.sv
//==============================================================================
// Module  : rbs_sub
// Brief   : Combinational ripple-borrow subtractor, d = x - y - b_in.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rbs_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         b_in,
    output logic [W-1:0] d,
    output logic         b_out
);

    logic [W:0] w_borrow;

    assign w_borrow[0] = b_in;

    generate
        for (genvar i = 0; i < W; i++) begin : g_cell
            assign d[i]          = x[i] ^ y[i] ^ w_borrow[i];
            assign w_borrow[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_borrow[i]);
        end
    endgenerate

    assign b_out = w_borrow[W];

endmodule

`default_nettype wire

// File: rtl/seq_restoring_div.sv
//==============================================================================
// Module  : seq_restoring_div
// Brief   : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              C_CNT_W = cnt_width(WIDTH);
    localparam [C_CNT_W-1:0]    C_LAST  = C_CNT_W'(WIDTH - 1);

    div_state_t         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic [WIDTH:0]     w_rs;
    logic [WIDTH:0]     w_d;
    logic               w_b;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_r_next;
    logic               w_unused_msb;

    // The partial remainder never reaches the divisor after restoring, so its
    // top bit is always zero between iterations and need not be stored.
    assign w_rs = {r_r, r_q[WIDTH-1]};

    rbs_sub #(
        .W(WIDTH + 1)
    ) u_sub (
        .x    (w_rs),
        .y    ({1'b0, r_div}),
        .b_in (1'b0),
        .d    (w_d),
        .b_out(w_b)
    );

    assign w_unused_msb = w_d[WIDTH];
    assign w_q_next     = {r_q[WIDTH-2:0], ~w_b};
    assign w_r_next     = w_b ? w_rs[WIDTH-1:0] : w_d[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_div       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q   <= dividend;
                        r_r   <= '0;
                        r_cnt <= '0;
                        r_div <= divisor;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + 1'b1;
                    r_dbz <= 1'b0;
                    if (r_cnt == C_LAST) begin
                        r_state     <= DONE;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_div.sv
//==============================================================================
// Module  : tb_seq_restoring_div
// Brief   : Self-checking bench for seq_restoring_div against an arithmetic model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_restoring_div;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;
    int results = 0;

    seq_restoring_div #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands and hold them until the handshake edge has passed.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int stall, input bit pulse, input bit chk_lat);
        int exp_q, exp_r, exp_dbz, lat, busy_bad, hold_bad;
        exp_dbz  = (b == 0) ? 1 : 0;
        exp_q    = (b == 0) ? (1 << WIDTH) - 1 : int'(a) / int'(b);
        exp_r    = (b == 0) ? int'(a) : int'(a) % int'(b);
        lat      = 0;
        busy_bad = 0;
        hold_bad = 0;
        send(a, b);
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad++;
            lat++;
            @(negedge clk);
        end
        check("out_valid_seen", out_valid, 1'b1);
        if (chk_lat) check("latency", lat, (b == 0) ? 0 : WIDTH);
        for (int i = 0; i < stall; i++) begin
            if (in_ready || !out_valid) busy_bad++;
            if (quotient !== WIDTH'(exp_q) || remainder !== WIDTH'(exp_r)) hold_bad++;
            if (pulse) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("busy_in_ready", busy_bad, 0);
        check("hold_stable", hold_bad, 0);
        check($sformatf("q %0d/%0d", a, b), quotient, exp_q);
        check($sformatf("r %0d/%0d", a, b), remainder, exp_r);
        check($sformatf("dbz %0d/%0d", a, b), div_by_zero, exp_dbz);
        results++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("ready_after", in_ready, 1'b1);
    endtask

    initial begin
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd13, 4'd3, 0, 1'b0, 1'b1);
        run_op(4'd9,  4'd0, 0, 1'b0, 1'b1);
        run_op(4'd15, 4'd1, 0, 1'b0, 1'b1);
        run_op(4'd5,  4'd7, 0, 1'b0, 1'b1);
        run_op(4'd0,  4'd6, 0, 1'b0, 1'b1);

        // Long stall with stray in_valid pulses that must not be queued.
        run_op(4'd11, 4'd2, 10, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_extra_result", out_valid, 1'b0);
        end

        // Abort mid-calculation after two iterations.
        send(4'd13, 4'd3);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 1'b0);
        end
        run_op(4'd14, 4'd4, 0, 1'b0, 1'b1);

        results = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(WIDTH'(a), WIDTH'(b), $urandom_range(0, 3), 1'b0, 1'b1);
            end
        end
        check("scoreboard_count", results, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
